// File: rtl/mode_cmd_pkg.sv
// Shared constants, command encoding and byte decoder for the menu mode arbiter.
package mode_cmd_pkg;

  localparam logic [7:0] CMD_L      = 8'h4C;
  localparam logic [7:0] CMD_R      = 8'h52;
  localparam logic [7:0] CMD_U      = 8'h55;
  localparam logic [7:0] CMD_D      = 8'h44;
  localparam logic [7:0] CMD_HOME   = 8'h48;
  localparam logic [7:0] CMD_CR     = 8'h0D;
  localparam logic [7:0] CMD_LF     = 8'h0A;
  localparam logic [7:0] DIGIT_BASE = 8'h30;
  localparam logic [7:0] CASE_BIT   = 8'h20;

  typedef enum logic [2:0] {
    NOP,
    INC_LR,
    DEC_LR,
    INC_UD,
    DEC_UD,
    SET_LR,
    HOME,
    ERR
  } cmd_e;

  typedef struct packed {
    cmd_e       op;
    logic [3:0] digit;
  } cmd_t;

  typedef struct packed {
    logic l;
    logic r;
    logic u;
    logic d;
  } btn_t;

  // Letters are matched case-insensitively by clearing the ASCII case bit.
  function automatic cmd_t decode_byte(input logic [7:0] b);
    cmd_t       c;
    logic [7:0] up;
    c.op    = ERR;
    c.digit = 4'd0;
    up      = b & ~CASE_BIT;
    if (b == CMD_CR || b == CMD_LF) begin
      c.op = NOP;
    end else if (b >= DIGIT_BASE && b < DIGIT_BASE + 8'd10) begin
      c.op    = SET_LR;
      c.digit = 4'(b - DIGIT_BASE);
    end else begin
      case (up)
        CMD_L:    c.op = DEC_LR;
        CMD_R:    c.op = INC_LR;
        CMD_U:    c.op = INC_UD;
        CMD_D:    c.op = DEC_UD;
        CMD_HOME: c.op = HOME;
        default:  c.op = ERR;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small power-of-two FIFO with registered level, full and empty flags.
module byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LVL_W-1:0] level_nxt;

  always_comb begin
    do_push   = push && !full;
    do_pop    = pop && !empty;
    level_nxt = level;
    case ({do_push, do_pop})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt;
      full  <= (level_nxt == LVL_W'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage needs no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/mode_cmd_arbiter.sv
// Merges button edges and queued UART command bytes into one LR/UD menu state,
// one decision per cycle with buttons taking priority over the byte queue.
module mode_cmd_arbiter
  import mode_cmd_pkg::*;
#(
  parameter int unsigned LR_MODES   = 4,
  parameter int unsigned UD_MODES   = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned LR_W  = $clog2(LR_MODES),
  localparam int unsigned UD_W  = $clog2(UD_MODES),
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_l,
  input  logic             btn_r,
  input  logic             btn_u,
  input  logic             btn_d,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ren,
  output logic [LR_W-1:0]  lr_mode,
  output logic [UD_W-1:0]  ud_mode,
  output logic             mode_changed,
  output logic             cmd_err,
  output logic [LVL_W-1:0] fifo_level
);

  btn_t            btn;
  btn_t            btn_q;
  btn_t            rise;
  logic            btn_evt;
  logic            capture;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      head;
  cmd_t            cmd;
  logic [LR_W-1:0] lr_inc;
  logic [LR_W-1:0] lr_dec;
  logic [UD_W-1:0] ud_inc;
  logic [UD_W-1:0] ud_dec;
  logic [LR_W-1:0] lr_nxt;
  logic [UD_W-1:0] ud_nxt;
  logic            err_nxt;

  assign btn     = '{l: btn_l, r: btn_r, u: btn_u, d: btn_d};
  assign rise    = btn & ~btn_q;
  assign btn_evt = |rise;
  // rx_ren high blocks a second capture of the byte still being acknowledged.
  assign capture = rx_valid && !rx_ren && !fifo_full;
  assign pop     = !btn_evt && !fifo_empty;
  assign cmd     = decode_byte(head);

  assign lr_inc = (lr_mode == LR_W'(LR_MODES - 1)) ? '0 : lr_mode + LR_W'(1);
  assign lr_dec = (lr_mode == '0) ? LR_W'(LR_MODES - 1) : lr_mode - LR_W'(1);
  assign ud_inc = (ud_mode == UD_W'(UD_MODES - 1)) ? '0 : ud_mode + UD_W'(1);
  assign ud_dec = (ud_mode == '0) ? UD_W'(UD_MODES - 1) : ud_mode - UD_W'(1);

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture),
    .wdata (rx_data),
    .pop   (pop),
    .rdata (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Opposing edges on the same axis cancel; the two axes are independent.
  always_comb begin
    lr_nxt  = lr_mode;
    ud_nxt  = ud_mode;
    err_nxt = 1'b0;
    if (btn_evt) begin
      if (rise.r && !rise.l)      lr_nxt = lr_inc;
      else if (rise.l && !rise.r) lr_nxt = lr_dec;
      if (rise.u && !rise.d)      ud_nxt = ud_inc;
      else if (rise.d && !rise.u) ud_nxt = ud_dec;
    end else if (pop) begin
      case (cmd.op)
        INC_LR: lr_nxt = lr_inc;
        DEC_LR: lr_nxt = lr_dec;
        INC_UD: ud_nxt = ud_inc;
        DEC_UD: ud_nxt = ud_dec;
        SET_LR: begin
          if (32'(cmd.digit) < LR_MODES) lr_nxt = LR_W'(cmd.digit);
          else                           err_nxt = 1'b1;
        end
        HOME: begin
          lr_nxt = '0;
          ud_nxt = '0;
        end
        ERR:     err_nxt = 1'b1;
        default: err_nxt = 1'b0;
      endcase
    end
  end

  // Edge history resets high so a button held through reset is not an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q        <= '{l: 1'b1, r: 1'b1, u: 1'b1, d: 1'b1};
      lr_mode      <= '0;
      ud_mode      <= '0;
      mode_changed <= 1'b0;
      cmd_err      <= 1'b0;
      rx_ren       <= 1'b0;
    end else begin
      btn_q        <= btn;
      lr_mode      <= lr_nxt;
      ud_mode      <= ud_nxt;
      mode_changed <= (lr_nxt != lr_mode) || (ud_nxt != ud_mode);
      cmd_err      <= err_nxt;
      rx_ren       <= capture;
    end
  end

endmodule
